dnn_output_evaluator: RTL and testbench
=======================================

Name: dnn_output_evaluator

Overview:
- Sits at the far end of the network, downstream of DNN_top.
- Deserializes the per-clock ideal-output stream (ansL) back into a full per-case ideal vector.
- On each case-complete strobe, compares that vector with the network's actual output vector (actL_alln) and scores the case.
- Accumulates per-window and cumulative correct counts for training-accuracy monitoring.

Parameters:
- NOUT, 10, dataset output count; only bits [NOUT-1:0] are scored.
- NL, 64, output-layer neuron count (width of actL_alln).
- ZO, 1, ideal bits per beat (z[L-2]/fi[L-2]); NL % ZO == 0.
- WINDOW, 1000, cases per accuracy window (>= 1).
- CNT_W, 32, width of the cumulative counters.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low (0 = in reset).
- ansL_valid, input, 1, ansL beat valid this clock.
- ansL, input, ZO, ideal bits; beat k carries ideal bits [k*ZO +: ZO].
- case_valid, input, 1, one-clock strobe: actL_alln is final for the current case.
- actL_alln, input, NL, thresholded actual outputs.
- case_done, output, 1, one-clock pulse: a case was scored.
- case_correct, output, 1, result of the last scored case; held until the next case_done.
- window_done, output, 1, one-clock pulse when WINDOW cases have been scored.
- window_correct, output, clog2(WINDOW+1), correct count of the last completed window; held.
- total_cases, output, CNT_W, cumulative scored cases; saturating.
- total_correct, output, CNT_W, cumulative correct cases; saturating.
- ideal_miss, output, 1, sticky: case_valid arrived with no full ideal vector.
- ideal_overrun, output, 1, sticky: a new vector started before the previous one was consumed.

Behaviour:
- Reset (async, reset = 0): all outputs 0, beat counter 0, state FILL, window counters 0. Deassertion is synchronized internally.
- Deserializer states:
  - FILL: each ansL_valid writes ansL into ideal_buf[beat*ZO +: ZO] and increments beat. On beat NL/ZO-1, beat wraps to 0 and the state moves to FULL.
  - FULL: the buffer is frozen. case_valid consumes it and returns the state to FILL.
  - A beat arriving in FULL without case_valid in the same cycle sets ideal_overrun. That beat is written as beat 0 of a new vector, the old vector is discarded, and the state goes to FILL.
- Same-cycle events:
  - case_valid together with the final beat in FILL: the final beat is bypassed into the comparison, and the case is scored normally. The state stays FILL with beat 0.
  - case_valid together with a beat in FULL: the old vector is scored, the beat starts the new vector, and no overrun is flagged.
- Missing vector: case_valid in FILL (other than the bypass case) sets ideal_miss. No case_done, and no counters change.
- Scoring:
  - correct = (actL_alln[NOUT-1:0] == ideal[NOUT-1:0]).
  - Bits NOUT..NL-1 are ignored.
  - Latency: case_valid at cycle t gives case_done and case_correct at t+1, both registered.
- Window:
  - win_cases and win_correct increment with each scored case.
  - When the scored case makes win_cases == WINDOW: at the same t+1 edge, window_done pulses, window_correct gets the count including that case, and both window counters clear to 0.
- Cumulative counters: total_cases and total_correct saturate at 2^CNT_W-1 and never wrap.
- ideal_miss and ideal_overrun clear only on reset.
- Reset mid-vector discards the partial vector. Reset mid-window discards the window with no window_done.

Decomposition:
- Package dnn_eval_pkg holds:
  - typedef eval_state_t {FILL, FULL};
  - function sat_inc(value, enable) for saturating counters;
  - constant BEATS = NL/ZO.
- One sub-module is natural: ideal_deserializer, which contains the buffer, beat counter, state machine, bypass and overrun logic. It outputs ideal_vec and vec_ready to the scoring/counter logic in the parent.

Test Plan:
- Reset, then 64 beats with ansL = 1 only on beat 3. case_valid one cycle after the last beat with actL_alln = 64'h8 → one clock later: case_done = 1, case_correct = 1, total_cases = 1, total_correct = 1.
- Same ideal vector, actL_alln = 64'h10 → case_correct = 0 and total_correct unchanged. Repeat with actL_alln = 64'h8 | (1<<40) → case_correct = 1, since bits at or above NOUT are ignored.
- case_valid in the same cycle as beat 63 → scored correctly (bypass path); the next beat is taken as beat 0 of the next vector; no error flags.
- 64 beats, no case_valid, then 1 further beat → ideal_overrun = 1. A later case_valid before 64 more beats → ideal_miss = 1 and total_cases unchanged.
- WINDOW = 4, cases scored correct, wrong, correct, correct → window_done pulses once, on the 4th case_done cycle, with window_correct = 3. Window counters restart, and the next window of 4 correct cases gives window_correct = 4.
- reset driven to 0 asynchronously mid-vector after 30 beats → all outputs 0 immediately. After release, a full 64-beat vector scores normally.

Source files
------------

// File: rtl/dnn_eval_pkg.sv
// dnn_eval_pkg: shared types, default geometry and saturating-increment helper
package dnn_eval_pkg;

    typedef enum logic {FILL, FULL} eval_state_t;

    localparam int NL_DEF = 64;
    localparam int ZO_DEF = 1;
    localparam int BEATS  = NL_DEF / ZO_DEF;

    // Widths up to 64 bits; the caller zero-extends the value in and truncates the result out
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width, input logic enable);
        logic [63:0] max;
        max = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (enable && value < max) ? value + 64'd1 : value;
    endfunction

endpackage

// File: rtl/dnn_output_evaluator_ideal_deserializer.sv
// ideal_deserializer: rebuilds the ideal vector from ZO-bit beats, with final-beat bypass and overrun detection
module ideal_deserializer
    import dnn_eval_pkg::*;
#(
    parameter int NL = 64,
    parameter int ZO = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_beat_valid,
    input  logic [ZO-1:0] i_beat,
    input  logic          i_consume,
    output logic [NL-1:0] o_ideal_vec,
    output logic          o_vec_ready,
    output logic          o_overrun
);
    localparam int NB = NL / ZO;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    eval_state_t   r_state, w_state_nxt;
    logic [BW-1:0] r_beat, w_beat_nxt, w_idx;
    logic [NL-1:0] r_buf, w_buf_nxt;
    logic          w_last;

    // A beat in FULL always lands in slot 0 of a fresh vector; the FILL view with the
    // incoming beat merged in is what lets a same-cycle final beat be scored directly
    always_comb begin
        w_idx       = (r_state == FULL) ? '0 : r_beat;
        w_last      = (w_idx == BW'(NB - 1));
        w_buf_nxt   = r_buf;
        if (i_beat_valid) w_buf_nxt[int'(w_idx)*ZO +: ZO] = i_beat;
        w_beat_nxt  = !i_beat_valid ? r_beat : (w_last ? '0 : w_idx + 1'b1);
        w_state_nxt = i_beat_valid ? ((w_last && !(r_state == FILL && i_consume)) ? FULL : FILL)
                                   : (i_consume ? FILL : r_state);
        o_vec_ready = (r_state == FULL) || (i_beat_valid && w_last);
        o_ideal_vec = (r_state == FULL) ? r_buf : w_buf_nxt;
        o_overrun   = (r_state == FULL) && i_beat_valid && !i_consume;
    end

    // Buffer, beat counter and state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FILL;
            r_beat  <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

endmodule

// File: rtl/dnn_output_evaluator.sv
// dnn_output_evaluator: scores each case against the deserialized ideal vector and keeps accuracy counters
module dnn_output_evaluator
    import dnn_eval_pkg::*;
#(
    parameter int NOUT   = 10,
    parameter int NL     = NL_DEF,
    parameter int ZO     = ZO_DEF,
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 32,
    localparam int WW    = $clog2(WINDOW + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ansl_valid,
    input  logic [ZO-1:0]    i_ansl,
    input  logic             i_case_valid,
    input  logic [NL-1:0]    i_actl_alln,
    output logic             o_case_done,
    output logic             o_case_correct,
    output logic             o_window_done,
    output logic [WW-1:0]    o_window_correct,
    output logic [CNT_W-1:0] o_total_cases,
    output logic [CNT_W-1:0] o_total_correct,
    output logic             o_ideal_miss,
    output logic             o_ideal_overrun
);
    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [NL-1:0] w_ideal_vec;
    logic          w_vec_ready, w_overrun, w_score, w_correct, w_win_hit;
    logic [WW-1:0] r_win_cases, r_win_correct, w_win_correct_inc;

    // Reset asserts asynchronously and releases two clocks later, in step with clk
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    ideal_deserializer #(.NL(NL), .ZO(ZO)) u_deser (
        .i_clk        (i_clk),
        .i_rst_n      (w_rst_n),
        .i_beat_valid (i_ansl_valid),
        .i_beat       (i_ansl),
        .i_consume    (i_case_valid),
        .o_ideal_vec  (w_ideal_vec),
        .o_vec_ready  (w_vec_ready),
        .o_overrun    (w_overrun)
    );

    // Only the dataset outputs are scored; the unused output-layer neurons are ignored
    always_comb begin
        w_score           = i_case_valid && w_vec_ready;
        w_correct         = (i_actl_alln[NOUT-1:0] == w_ideal_vec[NOUT-1:0]);
        w_win_hit         = (r_win_cases == WW'(WINDOW - 1));
        w_win_correct_inc = r_win_correct + WW'(w_correct);
    end

    // Case result, window and cumulative counters, sticky error flags
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            o_case_done      <= 1'b0;
            o_case_correct   <= 1'b0;
            o_window_done    <= 1'b0;
            o_window_correct <= '0;
            o_total_cases    <= '0;
            o_total_correct  <= '0;
            o_ideal_miss     <= 1'b0;
            o_ideal_overrun  <= 1'b0;
            r_win_cases      <= '0;
            r_win_correct    <= '0;
        end else begin
            o_case_done     <= w_score;
            o_window_done   <= w_score && w_win_hit;
            o_total_cases   <= CNT_W'(sat_inc(64'(o_total_cases), CNT_W, w_score));
            o_total_correct <= CNT_W'(sat_inc(64'(o_total_correct), CNT_W, w_score && w_correct));
            o_ideal_miss    <= o_ideal_miss || (i_case_valid && !w_vec_ready);
            o_ideal_overrun <= o_ideal_overrun || w_overrun;
            if (w_score) begin
                o_case_correct <= w_correct;
                if (w_win_hit) begin
                    o_window_correct <= w_win_correct_inc;
                    r_win_cases      <= '0;
                    r_win_correct    <= '0;
                end else begin
                    r_win_cases      <= r_win_cases + 1'b1;
                    r_win_correct    <= w_win_correct_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_output_evaluator.sv
// tb_dnn_output_evaluator: directed scenario tasks for the output evaluator
module tb_dnn_output_evaluator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ansl_valid = 1'b0;
    logic [0:0]  ansl = '0;
    logic        case_valid = 1'b0;
    logic [63:0] actl = '0;
    logic        case_done, case_correct, window_done, ideal_miss, ideal_overrun;
    logic [2:0]  window_correct;
    logic [31:0] total_cases, total_correct;
    logic        s_case_done, s_case_correct, s_window_done, s_ideal_miss, s_ideal_overrun;
    logic [2:0]  s_window_correct;
    logic [1:0]  s_total_cases, s_total_correct;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dnn_output_evaluator #(.NOUT(10), .NL(64), .ZO(1), .WINDOW(4), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(reset_n), .i_ansl_valid(ansl_valid), .i_ansl(ansl),
        .i_case_valid(case_valid), .i_actl_alln(actl),
        .o_case_done(case_done), .o_case_correct(case_correct), .o_window_done(window_done),
        .o_window_correct(window_correct), .o_total_cases(total_cases), .o_total_correct(total_correct),
        .o_ideal_miss(ideal_miss), .o_ideal_overrun(ideal_overrun)
    );

    // Narrow-counter copy sharing the same stimulus, to reach counter saturation
    dnn_output_evaluator #(.NOUT(10), .NL(64), .ZO(1), .WINDOW(4), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_reset(reset_n), .i_ansl_valid(ansl_valid), .i_ansl(ansl),
        .i_case_valid(case_valid), .i_actl_alln(actl),
        .o_case_done(s_case_done), .o_case_correct(s_case_correct), .o_window_done(s_window_done),
        .o_window_correct(s_window_correct), .o_total_cases(s_total_cases), .o_total_correct(s_total_correct),
        .o_ideal_miss(s_ideal_miss), .o_ideal_overrun(s_ideal_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [63:0] v, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            ansl_valid = 1'b1;
            ansl = v[k];
            tick();
        end
        ansl_valid = 1'b0;
        ansl = '0;
    endtask

    task automatic score(input logic [63:0] a);
        case_valid = 1'b1;
        actl = a;
        tick();
        case_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({case_done, case_correct, window_done, window_correct, total_cases, total_correct, ideal_miss, ideal_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%0b corr=%0b wdone=%0b wc=%0d tc=%0d tk=%0d miss=%0b ovr=%0b want all 0",
                     case_done, case_correct, window_done, window_correct, total_cases, total_correct, ideal_miss, ideal_overrun);
        end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        send_beats(64'h8, 0, 63);
        score(64'h8);
        n_checks++;
        if ({case_done, case_correct} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_result: got done=%0b correct=%0b want 1 1", case_done, case_correct);
        end
        n_checks++;
        if (total_cases !== 32'd1 || total_correct !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_totals: got %0d/%0d want 1/1", total_cases, total_correct);
        end
        tick();
        n_checks++;
        if (case_done !== 1'b0 || case_correct !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pulse: got done=%0b correct=%0b want 0 1", case_done, case_correct);
        end
    endtask

    task automatic test_ignore_high();
        send_beats(64'h8, 0, 63);
        score(64'h10);
        n_checks++;
        if ({case_done, case_correct} !== 2'b10 || total_cases !== 32'd2 || total_correct !== 32'd1) begin
            n_fail++;
            $display("FAIL wrong_case: got done=%0b correct=%0b tot=%0d/%0d want 1 0 2/1", case_done, case_correct, total_cases, total_correct);
        end
        send_beats(64'h8, 0, 63);
        score(64'h8 | (64'd1 << 40));
        n_checks++;
        if ({case_done, case_correct} !== 2'b11 || total_cases !== 32'd3 || total_correct !== 32'd2) begin
            n_fail++;
            $display("FAIL high_bits_ignored: got done=%0b correct=%0b tot=%0d/%0d want 1 1 3/2", case_done, case_correct, total_cases, total_correct);
        end
        n_checks++;
        if (window_done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_window: got window_done=%0b want 0", window_done);
        end
    endtask

    task automatic test_bypass();
        send_beats(64'h8, 0, 62);
        ansl_valid = 1'b1;
        ansl = 1'b0;
        score(64'h8);
        ansl_valid = 1'b0;
        n_checks++;
        if ({case_done, case_correct} !== 2'b11 || total_cases !== 32'd4 || total_correct !== 32'd3) begin
            n_fail++;
            $display("FAIL bypass_score: got done=%0b correct=%0b tot=%0d/%0d want 1 1 4/3", case_done, case_correct, total_cases, total_correct);
        end
        n_checks++;
        if (window_done !== 1'b1 || window_correct !== 3'd3) begin
            n_fail++;
            $display("FAIL window1: got done=%0b correct=%0d want 1 3", window_done, window_correct);
        end
        n_checks++;
        if (ideal_miss !== 1'b0 || ideal_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_flags: got miss=%0b overrun=%0b want 0 0", ideal_miss, ideal_overrun);
        end
        tick();
        n_checks++;
        if (window_done !== 1'b0 || window_correct !== 3'd3) begin
            n_fail++;
            $display("FAIL window1_hold: got done=%0b correct=%0d want 0 3", window_done, window_correct);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v2;
        v2 = 64'h200;
        send_beats(64'h8, 0, 63);
        score(64'h8);
        n_checks++;
        if ({case_done, case_correct, window_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%0b correct=%0b wdone=%0b want 1 1 0", case_done, case_correct, window_done);
        end
        send_beats(64'h8, 0, 63);
        ansl_valid = 1'b1;
        ansl = v2[0];
        score(64'h8);
        ansl_valid = 1'b0;
        n_checks++;
        if ({case_done, case_correct, ideal_overrun, ideal_miss} !== 4'b1100) begin
            n_fail++;
            $display("FAIL full_plus_beat: got done=%0b correct=%0b ovr=%0b miss=%0b want 1 1 0 0", case_done, case_correct, ideal_overrun, ideal_miss);
        end
        send_beats(v2, 1, 63);
        score(64'h200);
        n_checks++;
        if ({case_done, case_correct, window_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL new_vector_score: got done=%0b correct=%0b wdone=%0b want 1 1 0", case_done, case_correct, window_done);
        end
        send_beats(64'h1, 0, 63);
        score(64'h1);
        n_checks++;
        if (window_done !== 1'b1 || window_correct !== 3'd4) begin
            n_fail++;
            $display("FAIL window2: got done=%0b correct=%0d want 1 4", window_done, window_correct);
        end
        n_checks++;
        if (total_cases !== 32'd8 || total_correct !== 32'd7) begin
            n_fail++;
            $display("FAIL totals8: got %0d/%0d want 8/7", total_cases, total_correct);
        end
        n_checks++;
        if (s_total_cases !== 2'd3 || s_total_correct !== 2'd3) begin
            n_fail++;
            $display("FAIL saturation: got %0d/%0d want 3/3", s_total_cases, s_total_correct);
        end
    endtask

    task automatic test_errors();
        send_beats(64'h8, 0, 63);
        n_checks++;
        if (ideal_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_early: got %0b want 0", ideal_overrun);
        end
        send_beats(64'h0, 0, 0);
        n_checks++;
        if (ideal_overrun !== 1'b1 || ideal_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_set: got ovr=%0b miss=%0b want 1 0", ideal_overrun, ideal_miss);
        end
        score(64'h8);
        n_checks++;
        if (case_done !== 1'b0 || ideal_miss !== 1'b1 || total_cases !== 32'd8 || total_correct !== 32'd7) begin
            n_fail++;
            $display("FAIL miss: got done=%0b miss=%0b tot=%0d/%0d want 0 1 8/7", case_done, ideal_miss, total_cases, total_correct);
        end
        repeat (2) tick();
        n_checks++;
        if (ideal_miss !== 1'b1 || ideal_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky: got miss=%0b ovr=%0b want 1 1", ideal_miss, ideal_overrun);
        end
    endtask

    task automatic test_async_reset();
        send_beats(64'hFFFF, 0, 29);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({case_correct, window_correct, total_cases, total_correct, ideal_miss, ideal_overrun} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got corr=%0b wc=%0d tot=%0d/%0d miss=%0b ovr=%0b want all 0",
                     case_correct, window_correct, total_cases, total_correct, ideal_miss, ideal_overrun);
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        send_beats(64'h8, 0, 63);
        score(64'h8);
        n_checks++;
        if ({case_done, case_correct} !== 2'b11 || total_cases !== 32'd1 || total_correct !== 32'd1 || ideal_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got done=%0b correct=%0b tot=%0d/%0d miss=%0b want 1 1 1/1 0",
                     case_done, case_correct, total_cases, total_correct, ideal_miss);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_high();
        test_bypass();
        test_back_to_back();
        test_errors();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
